hd44780_ram_sequencer: RTL and testbench

- Read-side client of the LCD command RAM: walks 16-bit entries from a start address through the RAM read port and decodes each one.
- Each entry becomes one LCD byte transfer, one timed delay, or a stop.
- Bytes are handed to the downstream HD44780 bus driver over a valid/ready handshake.
- The RAM is written by the host on the other port; this block only ever reads.

---
 rtl/hd44780_ram_sequencer_if.sv | 32 +++
 rtl/hd44780_ram_sequencer.sv | 141 ++++++++++++++
 tb/tb_hd44780_ram_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hd44780_ram_sequencer_if.sv
// Purpose: RAM read port plus LCD byte stream between the sequencer and its neighbours.
// Latency: none, wires only.
// Backpressure: out_ready from the bus driver stalls the byte stream.
interface hd44780_ram_sequencer_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_rs;
  logic [7:0]            out_byte;

  modport master (
    output raddr,
    input  rdata,
    output out_valid,
    input  out_ready,
    output out_rs,
    output out_byte
  );

  modport slave (
    input  raddr,
    output rdata,
    input  out_valid,
    output out_ready,
    input  out_rs,
    input  out_byte
  );
endinterface

// File: rtl/hd44780_ram_sequencer.sv
// Purpose: walks LCD command RAM entries and turns them into byte sends, timed delays or a stop.
// Latency: 3 clocks per byte (fetch, wait, send); a delay of N ticks holds N*DELAY_PRESCALE+1 clocks.
// Backpressure: a byte and raddr are held until out_ready; optional HD44780_SEQ_LOOP_EN lets STOP[0]=1 restart.
module hd44780_ram_sequencer #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int DELAY_PRESCALE = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  hd44780_ram_sequencer_if.master bus,
  output logic                  busy,
  output logic                  done
);

  localparam int PW = (DELAY_PRESCALE > 1) ? $clog2(DELAY_PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DELAY_PRESCALE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SEND,
    S_DELAY
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [13:0]     tick_cnt;
  logic [PW-1:0]   pre_cnt;
  logic [1:0]      kind;
  logic            loop_hit;
  logic            handshake;

`ifdef HD44780_SEQ_LOOP_EN
  logic [ADDR_WIDTH-1:0] start_q;
  assign loop_hit = bus.rdata[0];
`else
  assign loop_hit = 1'b0;
`endif

  assign kind      = bus.rdata[15:14];
  assign handshake = bus.out_valid && bus.out_ready;
  assign busy      = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; the entry in rdata is only meaningful in WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT: begin
        case (kind)
          2'b00, 2'b01: state_nxt = S_SEND;
          2'b10:        state_nxt = S_DELAY;
          default:      state_nxt = loop_hit ? S_FETCH : S_IDLE;
        endcase
      end
      S_SEND:  if (handshake) state_nxt = S_FETCH;
      // The tick count reaching zero ends the delay: an N=0 entry leaves after one clock,
      // and N ticks cost exactly N full prescaler periods plus that final clock.
      S_DELAY: if (tick_cnt == 14'd0) state_nxt = S_FETCH;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address, output byte and delay counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.raddr     <= '0;
      bus.out_valid <= 1'b0;
      bus.out_rs    <= 1'b0;
      bus.out_byte  <= 8'd0;
      done          <= 1'b0;
      tick_cnt      <= 14'd0;
      pre_cnt       <= '0;
`ifdef HD44780_SEQ_LOOP_EN
      start_q       <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            bus.raddr <= start_addr;
`ifdef HD44780_SEQ_LOOP_EN
            start_q   <= start_addr;
`endif
          end
        end
        S_WAIT: begin
          case (kind)
            2'b00, 2'b01: begin
              bus.out_valid <= 1'b1;
              bus.out_byte  <= bus.rdata[7:0];
              bus.out_rs    <= kind[0];
            end
            2'b10: begin
              tick_cnt <= bus.rdata[13:0];
              pre_cnt  <= PRE_MAX;
            end
            default: begin
`ifdef HD44780_SEQ_LOOP_EN
              if (loop_hit) bus.raddr <= start_q;
              else          done      <= 1'b1;
`else
              done <= 1'b1;
`endif
            end
          endcase
        end
        S_SEND: begin
          if (handshake) begin
            bus.out_valid <= 1'b0;
            bus.raddr     <= bus.raddr + ADDR_WIDTH'(1);
          end
        end
        S_DELAY: begin
          if (tick_cnt == 14'd0) begin
            bus.raddr <= bus.raddr + ADDR_WIDTH'(1);
          end else if (pre_cnt == '0) begin
            pre_cnt  <= PRE_MAX;
            tick_cnt <= tick_cnt - 14'd1;
          end else begin
            pre_cnt <= pre_cnt - PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hd44780_ram_sequencer.sv
// Purpose: scoreboard bench for hd44780_ram_sequencer with a RAM model and an entry-walking reference.
// Latency: expected events carry the unstalled busy-cycle gap since the previous event.
// Backpressure: out_ready is driven always-high, randomly, held low for a burst, or held low.
module tb_hd44780_ram_sequencer;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] start_addr;
  logic       busy;
  logic       done;

  hd44780_ram_sequencer_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

  hd44780_ram_sequencer #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(16),
    .DELAY_PRESCALE(P)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .start_addr(start_addr),
    .bus(bus),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];

  // Synchronous-read RAM: raddr sampled on an edge, data valid the following cycle.
  always @(posedge clk) bus.rdata <= mem[bus.raddr];

  typedef struct {
    bit         is_done;
    bit         rs;
    logic [7:0] b;
    int         gap;
    logic [7:0] addr;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk = 0;
  int  n_fail = 0;
  int  ready_mode = 0;
  int  stall_left = 0;
  int  stall_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // out_ready driver, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (stall_left > 0) begin
          bus.out_ready = 1'b0;
          if (bus.out_valid) stall_left--;
        end else begin
          bus.out_ready = 1'b1;
        end
      end
      default: bus.out_ready = 1'b0;
    endcase
  end

  // Monitor: counts unstalled busy cycles, checks every transfer and done pulse against the queue.
  int         cnt = 0;
  bit         prev_stall = 0;
  logic [7:0] p_byte;
  logic [7:0] p_addr;
  logic       p_rs;
  ev_t        e;

  always @(negedge clk) begin
    if (reset) begin
      cnt = 0;
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_byte", bus.out_byte, p_byte);
        chk("stall_rs", bus.out_rs, p_rs);
        chk("stall_raddr", bus.raddr, p_addr);
      end
      prev_stall = 0;
      if (busy && !(bus.out_valid && !bus.out_ready)) cnt++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("ev_kind_byte", 0, e.is_done);
          chk("byte_rs", bus.out_rs, e.rs);
          chk("byte_val", bus.out_byte, e.b);
          chk("byte_raddr", bus.raddr, e.addr);
          chk("byte_gap", cnt, e.gap);
        end
        cnt = 0;
      end else if (bus.out_valid) begin
        prev_stall = 1;
        stall_seen++;
        p_byte = bus.out_byte;
        p_rs   = bus.out_rs;
        p_addr = bus.raddr;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("ev_kind_done", 1, e.is_done);
          chk("done_raddr", bus.raddr, e.addr);
          chk("done_gap", cnt, e.gap);
        end
        chk("done_busy", busy, 0);
        chk("done_excl_valid", bus.out_valid, 0);
        cnt = 0;
      end
    end
  end

  // Reference: walks the program as the entry format describes and queues the expected events.
  // Returns 1 when the run never ends on its own and the bench must reset it.
  function automatic bit model(input logic [7:0] sa);
    logic [7:0]  a = sa;
    logic [15:0] w;
    int          gap = 0;
    int          nev = 0;
    for (int i = 0; i < 600; i++) begin
      w = mem[a];
      case (w[15:14])
        2'b00, 2'b01: begin
          gap += 3;
          exp_q.push_back('{is_done: 1'b0, rs: w[14], b: w[7:0], gap: gap, addr: a});
          gap = 0;
          a++;
          nev++;
          if (nev >= 12) return 1;
        end
        2'b10: begin
          gap += 2 + int'(w[13:0]) * P + 1;
          a++;
        end
        default: begin
          gap += 2;
`ifdef HD44780_SEQ_LOOP_EN
          if (w[0]) begin
            a = sa;
            continue;
          end
`endif
          exp_q.push_back('{is_done: 1'b1, rs: 1'b0, b: 8'd0, gap: gap, addr: a});
          return 0;
        end
      endcase
    end
    return 1;
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic run(input logic [7:0] sa, input int intrude_at);
    bit trunc;
    int t = 0;
    trunc = model(sa);
    @(posedge clk);
    #2;
    start = 1'b1;
    start_addr = sa;
    @(posedge clk);
    #2;
    start = 1'b0;
    if (intrude_at > 0) begin
      repeat (intrude_at) @(posedge clk);
      #2;
      start = 1'b1;
      start_addr = sa + 8'h10;
      @(posedge clk);
      #2;
      start = 1'b0;
    end
    while (exp_q.size() > 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    if (trunc || exp_q.size() > 0) begin
      do_reset();
    end else begin
      repeat (3) @(posedge clk);
      #2;
      chk("idle_after_run", busy, 0);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sa;
    int         len;
    int         k;
    int         t;
    reset = 1'b1;
    start = 1'b0;
    start_addr = 8'd0;
    for (int i = 0; i < 256; i++) mem[i] = 16'hC000;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_raddr", bus.raddr, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_rs", bus.out_rs, 0);
    chk("rst_byte", bus.out_byte, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;

    // Basic program, ready always high.
    mem[8'h10] = 16'h0038;
    mem[8'h11] = 16'h4041;
    mem[8'h12] = 16'hC000;
    ready_mode = 0;
    run(8'h10, 0);
    chk("raddr_holds_idle", bus.raddr, 8'h12);

    // Same program, first byte stalled for 10 cycles.
    ready_mode = 2;
    stall_left = 10;
    stall_seen = 0;
    run(8'h10, 0);
    chk("stall_cycles", stall_seen, 10);
    ready_mode = 0;

    // Delay timing: 3 ticks and 0 ticks.
    mem[8'h20] = 16'h8003;
    mem[8'h21] = 16'hC000;
    run(8'h20, 0);
    mem[8'h20] = 16'h8000;
    run(8'h20, 0);

    // Address wrap.
    mem[8'hFF] = 16'h0001;
    mem[8'h00] = 16'hC000;
    run(8'hFF, 0);
    chk("wrap_raddr", bus.raddr, 8'h00);

    // Start during busy is ignored.
    mem[8'h40] = 16'h8005;
    mem[8'h41] = 16'h0042;
    mem[8'h42] = 16'hC000;
    mem[8'h50] = 16'h00EE;
    mem[8'h51] = 16'hC000;
    run(8'h40, 5);

    // Reset while a byte is pending and not accepted.
    mem[8'h30] = 16'h0077;
    mem[8'h31] = 16'hC000;
    ready_mode = 3;
    @(posedge clk);
    #2;
    start = 1'b1;
    start_addr = 8'h30;
    @(posedge clk);
    #2;
    start = 1'b0;
    t = 0;
    while (!bus.out_valid && t < 50) begin
      @(posedge clk);
      #2;
      t++;
    end
    chk("valid_before_reset", bus.out_valid, 1);
    reset = 1'b1;
    @(posedge clk);
    #2;
    chk("abort_valid", bus.out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_raddr", bus.raddr, 0);
    chk("abort_byte", bus.out_byte, 0);
    reset = 1'b0;
    exp_q.delete();
    ready_mode = 0;

`ifdef HD44780_SEQ_LOOP_EN
    // Looping program: bytes repeat, done never pulses.
    mem[8'h60] = 16'h0055;
    mem[8'h61] = 16'hC001;
    run(8'h60, 0);
`endif

    // Random programs with random backpressure.
    ready_mode = 1;
    for (int r = 0; r < 30; r++) begin
      sa  = 8'($urandom);
      len = $urandom_range(1, 8);
      for (int j = 0; j < len - 1; j++) begin
        k = $urandom_range(0, 2);
        if (k == 2) mem[8'(sa + j)] = {2'b10, 14'($urandom_range(0, 3))};
        else        mem[8'(sa + j)] = {1'b0, k[0], 6'($urandom), 8'($urandom)};
      end
      mem[8'(sa + len - 1)] = {2'b11, 14'($urandom)};
      run(sa, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
